cbus_master_seq: RTL
====================

Name: cbus_master_seq

Overview:
CBUS initiator that drives the cbus_req/cmd/address/wdata side of a CBUS slave, such as the SP-memory arbiter tops, and consumes its waccept/rresp/rddata. A local host issues single or burst commands; the block sequences one CBUS beat at a time with incrementing addresses. It streams write data in, streams read data out, and reports completion or timeout. Used for memory init, readback and debug access from on-chip controllers.

Parameters:
AW, 10, CBUS address width (CBUS_AW of the target).
DW, 32, data width; legal range 1..32.
BL_W, 4, burst-length field width; the burst is cmd_len+1 beats.
TO_CYC, 64, maximum cycles req may stay high for one beat before abort; must be at least 2.

Ports:
clk  in  1  clock
sreset  in  1  synchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  start address
cmd_len  in  BL_W  beats-1
wr_valid  in  1  write-data stream valid
wr_data  in  DW  write-data beat
wr_ready  out  1  write beat accepted this cycle
rd_valid  out  1  one-cycle pulse, read beat returned
rd_data  out  DW  read data, qualified by rd_valid
rd_last  out  1  final beat of the burst, with rd_valid
done  out  1  one-cycle pulse at command end
done_err  out  1  with done; 1 = timeout abort
busy  out  1  not IDLE
cbus_req  out  1  CBUS request
cbus_slv_cmd  out  1  1=write, 0=read
cbus_slv_address  out  AW  beat address
cbus_slv_wdata  out  DW  beat write data
cbus_waccept  in  1  write accepted
cbus_rresp  in  1  read response; cbus_rddata valid this cycle
cbus_rddata  in  32  read data; bits [DW-1:0] are used

Behaviour:
- Clocking and reset: clk only. sreset is synchronous and active-high.
- On reset, all outputs are 0 except cmd_ready=1; state=IDLE; counters cleared.
- Reset mid-burst: cbus_req is 0 after the edge; no done pulse; the partial burst is lost.
- State machine: IDLE, WDATA, REQ, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch write flag, address and beat counter (cmd_len).
  - Go to WDATA for a write, REQ for a read.
- WDATA:
  - wr_ready = wr_valid; wr_ready is high only in this state.
  - On wr_valid, register wr_data into cbus_slv_wdata and go to REQ next cycle.
  - There is no timeout while waiting for write data.
- REQ:
  - cbus_req=1. cmd, address and wdata stay stable for the whole state.
  - The timeout counter clears on entry and increments each cycle.
  - Write beat completes on cbus_waccept; read beat completes on cbus_rresp.
  - Read completion: rd_valid=1 and rd_data=cbus_rddata[DW-1:0] in the following cycle (registered); rd_last=1 if this was the final beat.
  - The wrong-type response (rresp during a write, waccept during a read) is ignored.
- Timeout:
  - If there is no completion by the TO_CYC-th cycle in REQ, drop req and go to IDLE.
  - done=1 and done_err=1 next cycle; remaining beats are abandoned.
  - For a read that times out, rd_valid is never asserted.
  - Completion and timeout in the same cycle: completion wins.
- GAP (after each completed beat):
  - cbus_req=0 for exactly one cycle, so every beat is a fresh request edge, compatible with slaves that pulse rresp every other cycle.
  - If beats remain: address += 1 modulo 2^AW (wraps 2^AW-1 → 0), decrement the counter, go to WDATA (write) or REQ (read).
  - If no beats remain: done=1, done_err=0, go to IDLE.
- Latency: a single read beat with rresp in the 2nd REQ cycle gives cbus_req high 2 cycles, then rd_valid, then done.
- There is no rd backpressure: the consumer must accept every rd_valid.
- cmd_ready is 0 while busy; cmd_valid outside IDLE is ignored.

Test Plan:
1. Single write, addr=0x12, data=0xA5A5A5A5, slave waccepts in 1st REQ cycle → req high 1 cycle with cmd=1, addr=0x12, wdata=0xA5A5A5A5; done=1, done_err=0 two cycles later.
2. Read burst of 4 at addr=0x3FE (AW=10), slave rresp after 2 cycles per beat → addresses 0x3FE, 0x3FF, 0x000, 0x001; req low one cycle between beats; 4 rd_valid pulses with rd_last on the 4th; then done.
3. Write burst of 3 with wr_valid gaps of 5 cycles → req stays low while waiting; wr_ready pulses exactly 3 times; each beat carries the correct data.
4. Read with no response, TO_CYC=64 → req high exactly 64 cycles; done=1, done_err=1; no rd_valid; cmd_ready=1 afterwards.
5. waccept arrives on the 64th REQ cycle → beat completes, done_err=0. Read command receiving a stray waccept → ignored, still waits for rresp.
6. sreset asserted during beat 2 of a 4-beat read → next cycle req=0, busy=0, no done; a new command then executes normally.

Source files
------------

// File: rtl/cbus_master_seq.sv
// cbus_master_seq: host-command CBUS initiator that issues single or burst beats with incrementing addresses.
// Each beat is a fresh request edge, and each beat is aborted after TO_CYC cycles without a response.
module cbus_master_seq #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int BL_W   = 4,
    parameter int TO_CYC = 64
) (
    input  logic            clk,
    input  logic            sreset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [BL_W-1:0] cmd_len,
    input  logic            wr_valid,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ready,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            done_err,
    output logic            busy,
    output logic            cbus_req,
    output logic            cbus_slv_cmd,
    output logic [AW-1:0]   cbus_slv_address,
    output logic [DW-1:0]   cbus_slv_wdata,
    input  logic            cbus_waccept,
    input  logic            cbus_rresp,
    input  logic [31:0]     cbus_rddata
);
    localparam int TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

    typedef enum logic [1:0] {IDLE, WDATA, REQ, GAP} state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BL_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]   to_q, to_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_last_q, rd_last_d;
    logic            done_q, done_d;
    logic            done_err_q, done_err_d;
    logic            cpl, expired;

    // Only the response matching the beat direction completes it.
    assign cpl     = write_q ? cbus_waccept : cbus_rresp;
    assign expired = to_q == TW'(TO_CYC - 1);

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        to_d       = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                write_d = cmd_write;
                addr_d  = cmd_addr;
                cnt_d   = cmd_len;
                state_d = cmd_write ? WDATA : REQ;
            end
            WDATA: if (wr_valid) begin
                wdata_d = wr_data;
                state_d = REQ;
            end
            REQ: begin
                to_d = to_q + TW'(1);
                if (cpl) begin
                    state_d    = GAP;
                    rd_valid_d = !write_q;
                    rd_data_d  = write_q ? rd_data_q : cbus_rddata[DW-1:0];
                    rd_last_d  = !write_q && cnt_q == '0;
                end else if (expired) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                addr_d  = addr_q + AW'(1);
                cnt_d   = cnt_q - BL_W'(1);
                state_d = write_q ? WDATA : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            to_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            to_q       <= to_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    assign cmd_ready        = state_q == IDLE;
    assign busy             = state_q != IDLE;
    assign wr_ready         = state_q == WDATA && wr_valid;
    assign cbus_req         = state_q == REQ;
    assign cbus_slv_cmd     = write_q;
    assign cbus_slv_address = addr_q;
    assign cbus_slv_wdata   = wdata_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign rd_last          = rd_last_q;
    assign done             = done_q;
    assign done_err         = done_err_q;
endmodule
